// File: rtl/onewire_master.sv
// Single-wire open-drain bus master: reset/presence, write-bit and read-bit slots
// issued one at a time over a valid/ready command port, one response per command.
module onewire_master #(
  parameter int CLK_DIV  = 50,
  parameter int T_RSTL   = 480,
  parameter int T_PDWAIT = 70,
  parameter int T_RSTH   = 410,
  parameter int T_SLOT   = 60,
  parameter int T_LOW1   = 6,
  parameter int T_LOW0   = 55,
  parameter int T_SAMPLE = 15,
  parameter int T_REC    = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_bit,
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic       rsp_err,
  output logic       busy,
  output logic       pad_c2p,
  output logic       pad_c2p_en,
  input  logic       pad_p2c
);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_WAIT, RST_HOLD, SLOT_LOW, SLOT_HIGH, RECOVER, DONE
  } state_t;

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  state_t      state_q;
  logic [15:0] presc_q, tcnt_q;
  logic [1:0]  op_q;
  logic        bit_q, sync1_q, sync2_q, smp_q;
  logic        c2p_en_q, rsp_valid_q, rsp_bit_q, rsp_err_q;

  logic        tick_d;
  logic [15:0] tlow_d, slot_end_d, smp_at_d;

  assign tick_d     = (presc_q == 16'(CLK_DIV - 1));
  assign tlow_d     = (op_q == OP_WR && !bit_q) ? 16'(T_LOW0) : 16'(T_LOW1);
  // SLOT_HIGH restarts the tick count, so slot-relative points are offset by the low phase
  assign slot_end_d = 16'(T_SLOT) - tlow_d - 16'd1;
  assign smp_at_d   = 16'(T_SAMPLE - T_LOW1 - 1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      tcnt_q      <= '0;
      op_q        <= OP_RST;
      bit_q       <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      smp_q       <= 1'b1;
      c2p_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      sync1_q     <= pad_p2c;
      sync2_q     <= sync1_q;
      rsp_valid_q <= 1'b0;
      if ((state_q == IDLE && cmd_valid) || tick_d) presc_q <= '0;
      else                                         presc_q <= presc_q + 16'd1;
      if (tick_d) tcnt_q <= tcnt_q + 16'd1;

      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q   <= cmd_op;
          bit_q  <= cmd_bit;
          tcnt_q <= '0;
          case (cmd_op)
            OP_RST: begin state_q <= RST_LOW;  c2p_en_q <= 1'b1; end
            OP_WR,
            OP_RD:  begin state_q <= SLOT_LOW; c2p_en_q <= 1'b1; end
            default: begin
              state_q     <= DONE;
              rsp_valid_q <= 1'b1;
              rsp_bit_q   <= 1'b0;
              rsp_err_q   <= 1'b1;
            end
          endcase
        end
        RST_LOW: if (tick_d && tcnt_q == 16'(T_RSTL - 1)) begin
          state_q  <= RST_WAIT;
          c2p_en_q <= 1'b0;
          tcnt_q   <= '0;
        end
        RST_WAIT: if (tick_d && tcnt_q == 16'(T_PDWAIT - 1)) begin
          state_q <= RST_HOLD;
          smp_q   <= ~sync2_q;
          tcnt_q  <= '0;
        end
        RST_HOLD: if (tick_d && tcnt_q == 16'(T_RSTH - 1)) begin
          state_q     <= DONE;
          rsp_valid_q <= 1'b1;
          rsp_bit_q   <= smp_q;
          rsp_err_q   <= ~sync2_q;
        end
        SLOT_LOW: if (tick_d && tcnt_q == tlow_d - 16'd1) begin
          state_q  <= SLOT_HIGH;
          c2p_en_q <= 1'b0;
          tcnt_q   <= '0;
        end
        SLOT_HIGH: if (tick_d) begin
          if (tcnt_q == smp_at_d) smp_q <= sync2_q;
          if (tcnt_q == slot_end_d) begin
            state_q <= RECOVER;
            tcnt_q  <= '0;
          end
        end
        RECOVER: if (tick_d && tcnt_q == 16'(T_REC - 1)) begin
          state_q     <= DONE;
          rsp_valid_q <= 1'b1;
          rsp_bit_q   <= (op_q == OP_RD) ? smp_q : bit_q;
          rsp_err_q   <= (op_q == OP_WR) & bit_q & ~smp_q;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = ~cmd_ready;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_bit    = rsp_bit_q;
  assign rsp_err    = rsp_err_q;
  assign pad_c2p    = 1'b0;
  assign pad_c2p_en = c2p_en_q;

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master: a CLK_DIV=1 instance with a scripted bus device
// and a CLK_DIV=4 instance for prescaler timing.
module tb_onewire_master;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_bit = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ready, rsp_valid, rsp_bit, rsp_err, busy, pad_c2p, pad_c2p_en, pad_p2c;
  logic       cmd_valid4 = 1'b0, cmd_bit4 = 1'b0;
  logic [1:0] cmd_op4 = 2'b00;
  logic       cmd_ready4, rsp_valid4, rsp_bit4, rsp_err4, busy4, pad_c2p4, pad_c2p_en4, pad_p2c4;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, rel;
  int low_cnt = 0, busy_cnt = 0, rsp_cnt = 0, low4_cnt = 0;
  int dev_mode = 0;
  logic dev_low;

  always #5 clk = ~clk;

  onewire_master #(.CLK_DIV(1)) u_dut (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_bit(cmd_bit), .rsp_valid(rsp_valid), .rsp_bit(rsp_bit),
    .rsp_err(rsp_err), .busy(busy), .pad_c2p(pad_c2p), .pad_c2p_en(pad_c2p_en),
    .pad_p2c(pad_p2c)
  );

  onewire_master #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op4), .cmd_bit(cmd_bit4), .rsp_valid(rsp_valid4), .rsp_bit(rsp_bit4),
    .rsp_err(rsp_err4), .busy(busy4), .pad_c2p(pad_c2p4), .pad_c2p_en(pad_c2p_en4),
    .pad_p2c(pad_p2c4)
  );

  // Bus device: rel counts clock edges since the last accepted command.
  assign rel = cyc - acc_cyc;
  always_comb begin
    dev_low = 1'b0;
    case (dev_mode)
      1: dev_low = (rel >= 500 && rel < 600);
      2: dev_low = 1'b1;
      3: dev_low = (rel < 30);
      4: dev_low = (rel < 6);
      default: dev_low = 1'b0;
    endcase
  end
  assign pad_p2c  = ~(pad_c2p_en | dev_low);
  assign pad_p2c4 = ~pad_c2p_en4;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (pad_c2p_en)  low_cnt  = low_cnt + 1;
    if (pad_c2p_en4) low4_cnt = low4_cnt + 1;
    if (busy)        busy_cnt = busy_cnt + 1;
    if (rsp_valid)   rsp_cnt  = rsp_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic b);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_bit = b;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Returns the number of negedges polled until rsp_valid, 0 on timeout.
  task automatic wait_rsp(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (rsp_valid) begin n = i; break; end
    end
  endtask

  int n, n2, l0, b0, r0, a1, lo1, b1, e1;

  initial begin
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_bit", rsp_bit, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_c2p", pad_c2p, 0);
    check("rst_c2p_en", pad_c2p_en, 0);

    // Reset with device presence pulse at 500..600 cycles after acceptance
    dev_mode = 1; l0 = low_cnt; b0 = busy_cnt;
    send(2'b00, 1'b0);
    wait_rsp(2000, n);
    check("pres_latency", n, 961);
    check("pres_bit", rsp_bit, 1);
    check("pres_err", rsp_err, 0);
    repeat (2) @(negedge clk);
    check("pres_low_cycles", low_cnt - l0, 480);
    check("pres_busy_cycles", busy_cnt - b0, 961);

    dev_mode = 0;
    send(2'b00, 1'b0);
    wait_rsp(2000, n);
    check("nodev_bit", rsp_bit, 0);
    check("nodev_err", rsp_err, 0);

    dev_mode = 2;
    send(2'b00, 1'b0);
    wait_rsp(2000, n);
    check("stuck_bit", rsp_bit, 1);
    check("stuck_err", rsp_err, 1);
    dev_mode = 0;
    repeat (3) @(negedge clk);

    // Write-0 then write-1 back to back
    l0 = low_cnt;
    send(2'b01, 1'b0);
    a1 = acc_cyc;
    wait_rsp(200, n);
    lo1 = low_cnt - l0; b1 = rsp_bit; e1 = rsp_err; l0 = low_cnt;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_bit = 1'b1;
    @(negedge clk);
    check("b2b_ready_after_done", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("b2b_accept_spacing", acc_cyc - a1, 64);
    wait_rsp(200, n2);
    check("w0_latency", n, 63);
    check("w0_low", lo1, 55);
    check("w0_bit", b1, 0);
    check("w0_err", e1, 0);
    check("w1_latency", n2, 63);
    check("w1_low", low_cnt - l0, 6);
    check("w1_bit", rsp_bit, 1);
    check("w1_err", rsp_err, 0);

    dev_mode = 3;
    send(2'b10, 1'b0);
    wait_rsp(200, n);
    check("rd_held_bit", rsp_bit, 0);
    check("rd_held_err", rsp_err, 0);
    dev_mode = 4;
    send(2'b10, 1'b0);
    wait_rsp(200, n);
    check("rd_rel_bit", rsp_bit, 1);

    dev_mode = 2;
    send(2'b01, 1'b1);
    wait_rsp(200, n);
    check("coll_bit", rsp_bit, 1);
    check("coll_err", rsp_err, 1);
    dev_mode = 0;
    repeat (3) @(negedge clk);

    l0 = low_cnt;
    send(2'b11, 1'b1);
    wait_rsp(20, n);
    check("ill_latency", n, 1);
    check("ill_bit", rsp_bit, 0);
    check("ill_err", rsp_err, 1);
    check("ill_no_drive", low_cnt - l0, 0);

    // Asynchronous abort in the middle of the reset-low phase
    send(2'b00, 1'b0);
    repeat (100) @(negedge clk);
    r0 = rsp_cnt;
    #2 nrst = 1'b0;
    #1;
    check("abort_c2p_en", pad_c2p_en, 0);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (1000) @(negedge clk);
    check("abort_no_rsp", rsp_cnt - r0, 0);
    check("abort_ready", cmd_ready, 1);
    send(2'b10, 1'b0);
    wait_rsp(200, n);
    check("abort_read_latency", n, 63);
    check("abort_read_bit", rsp_bit, 1);

    // Prescaled read on the CLK_DIV=4 instance
    l0 = low4_cnt; n = 0;
    @(negedge clk);
    cmd_valid4 = 1'b1; cmd_op4 = 2'b10; cmd_bit4 = 1'b0;
    @(posedge clk);
    #1 cmd_valid4 = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (rsp_valid4) begin n = i; break; end
    end
    check("div4_latency", n, 249);
    check("div4_low", low4_cnt - l0, 24);
    check("div4_bit", rsp_bit4, 1);
    check("div4_err", rsp_err4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
